// File: rtl/imem_loader_pkg.sv
// Shared constants and state encodings for the serial instruction-memory loader.
package imem_loader_pkg;

  localparam int INSTRUCTION_WIDTH                = 32;
  localparam int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT        = 868;  // 100 MHz / 115200

  // Framing FSM of the loader
  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR
  } loader_state_t;

  // Byte receiver phases
  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_BITS, RX_STOP
  } rx_state_t;

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, bit timer, mid-bit sampler.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  // sync[1] is the synchronised line, sync[2] its previous value for edge detection
  logic [2:0]    sync;
  rx_state_t     st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  // Receive state machine; byte_valid / frame_err are single-cycle pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync       <= 3'b111;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[1:0], rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (st)
        RX_IDLE:
          if (sync[2] && !sync[1]) begin
            st  <= RX_START;
            cnt <= '0;
          end
        RX_START:
          // A line already back high at mid-start is a glitch, not a frame
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_cnt <= '0;
            st      <= sync[1] ? RX_IDLE : RX_BITS;
          end else cnt <= cnt + 1'b1;
        RX_BITS:
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) st <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        RX_STOP:
          if (cnt == FULL_M1) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (sync[1]) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err  <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: frames UART bytes into words, writes instruction
// memory and holds the core in reset until a checksum-verified load completes.
module imem_loader #(
  parameter int CLKS_PER_BIT                     = imem_loader_pkg::UART_DEFAULT_CLKS_PER_BIT,
  parameter int INSTRUCTION_WIDTH                = imem_loader_pkg::INSTRUCTION_WIDTH,
  parameter int INSTRUCTION_MEMORY_ADDRESS_WIDTH = imem_loader_pkg::INSTRUCTION_MEMORY_ADDRESS_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        uart_rx,
  output logic                                        imem_w_en,
  output logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] imem_w_addr,
  output logic [INSTRUCTION_WIDTH-1:0]                imem_w_data,
  output logic                                        cpu_hold,
  output logic                                        load_done,
  output logic                                        load_error
);
  import imem_loader_pkg::*;

  localparam int AW = INSTRUCTION_MEMORY_ADDRESS_WIDTH;
  localparam int IW = INSTRUCTION_WIDTH;

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  loader_state_t  state;
  logic [7:0]     len_lo;
  logic [15:0]    len;
  logic [15:0]    word_idx;
  logic [1:0]     byte_idx;
  logic [2:0][7:0] word;      // low three bytes; the fourth arrives with the write
  logic [7:0]     checksum;
  logic [15:0]    len_new;

  assign len_new = {byte_data, len_lo};

  // Framing FSM with registered write port and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LEN_LO;
      len_lo      <= '0;
      len         <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      word        <= '0;
      checksum    <= '0;
      imem_w_en   <= 1'b0;
      imem_w_addr <= '0;
      imem_w_data <= '0;
      cpu_hold    <= 1'b1;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      imem_w_en <= 1'b0;
      if (frame_err && state != DONE) begin
        state      <= ERROR;
        cpu_hold   <= 1'b1;
        load_done  <= 1'b0;
        load_error <= 1'b1;
      end else if (byte_valid) begin
        case (state)
          LEN_LO: begin
            len_lo <= byte_data;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            len <= len_new;
            if (len_new == 16'd0 || 32'(len_new) > (32'd1 << AW)) begin
              state      <= ERROR;
              cpu_hold   <= 1'b1;
              load_done  <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            checksum <= checksum ^ byte_data;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              imem_w_en   <= 1'b1;
              imem_w_addr <= word_idx[AW-1:0];
              imem_w_data <= IW'({byte_data, word});
              word_idx    <= word_idx + 16'd1;
              if (word_idx == len - 16'd1) state <= CHECK;
            end else begin
              word[byte_idx] <= byte_data;
            end
          end
          CHECK: begin
            cpu_hold <= (byte_data != checksum);
            if (byte_data == checksum) begin
              state      <= DONE;
              load_done  <= 1'b1;
              load_error <= 1'b0;
            end else begin
              state      <= ERROR;
              load_done  <= 1'b0;
              load_error <= 1'b1;
            end
          end
          default: begin
            // DONE / ERROR: the byte is the LEN_LO of a fresh load
            len_lo     <= byte_data;
            state      <= LEN_HI;
            word_idx   <= '0;
            byte_idx   <= '0;
            checksum   <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Serial program loader that writes the RISC-V core's instruction memory from a UART link, so programs need no resynthesis.
- Receives a framed word stream, assembles 32-bit little-endian instructions, and issues word writes to the instruction memory write port.
- Holds the core in reset until a load completes with a valid checksum.
- Sits beside top_risc, between the board UART pin and the instruction memory.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4
INSTRUCTION_WIDTH, 32, instruction word width (from common_pkg)
INSTRUCTION_MEMORY_ADDRESS_WIDTH, 8, word-address width of instruction memory (from common_pkg)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
uart_rx  input  1  asynchronous serial input, idle high, 8N1, LSB first
imem_w_en  output  1  one-cycle write strobe to instruction memory
imem_w_addr  output  INSTRUCTION_MEMORY_ADDRESS_WIDTH  word address of write
imem_w_data  output  INSTRUCTION_WIDTH  instruction word to write
cpu_hold  output  1  high = hold core in reset
load_done  output  1  high after a successful load
load_error  output  1  high after a failed load

Behaviour:
- Reset (rst low, asynchronous): cpu_hold=1; imem_w_en=0; imem_w_addr=0; imem_w_data=0; load_done=0; load_error=0; FSM=LEN_LO; checksum=0; byte counter=0.
- Synchronise uart_rx through 2 flops; all logic uses the synchronised value.
- Receiver:
  - Start detected on a high-to-low transition, then re-sampled at CLKS_PER_BIT/2.
  - If the line is high at that re-sample, treat it as a glitch and return to idle with no byte.
  - Sample 8 data bits at CLKS_PER_BIT intervals, then the stop bit.
  - Stop bit 1: one-cycle byte_valid with byte_data.
  - Stop bit 0: one-cycle frame_err.
- Frame format: LEN_LO, LEN_HI (word count N, 16-bit, little-endian), then N×4 data bytes (each word little-endian), then 1 checksum byte equal to the XOR of all data bytes.
- FSM states:
  - LEN_LO: capture N[7:0].
  - LEN_HI: capture N[15:8]. If N==0 or N > 2**INSTRUCTION_MEMORY_ADDRESS_WIDTH, go to ERROR; else go to DATA.
  - DATA: shift each byte into a word register at position byte_idx (0..3) and XOR it into the checksum. After byte 3:
    - Cycle after the byte is accepted: imem_w_en=1 for exactly one cycle, with imem_w_addr = word index and imem_w_data = assembled word.
    - Word index increments after the write.
    - After word N-1 is written, go to CHECK.
  - CHECK: on the next byte, match → DONE; mismatch → ERROR.
  - DONE: load_done=1, cpu_hold=0, load_error=0.
  - ERROR: load_error=1, cpu_hold=1, load_done=0.
- frame_err in any state other than DONE goes to ERROR.
- In DONE or ERROR, a new valid byte restarts the load:
  - cpu_hold=1, load_done=0, load_error=0; word index, checksum and byte_idx cleared.
  - The byte is consumed as LEN_LO and the FSM moves to LEN_HI.
- Writes already issued are never rolled back on error. The core stays held, so they are harmless.
- Max write rate is 1 per 40 bit-times, so there is no back-pressure; the memory write port must accept a strobe every cycle.
- imem_w_addr wraps never: the N bound guarantees index ≤ 2**AW−1.

Decomposition:
- common_pkg additions:
  - loader_state_t enum (LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR).
  - UART_DEFAULT_CLKS_PER_BIT constant.
  - Existing INSTRUCTION_WIDTH and INSTRUCTION_MEMORY_ADDRESS_WIDTH.
- Sub-module uart_rx_byte (synchroniser, bit timer, sampler; outputs byte_valid, byte_data, frame_err).
- imem_loader holds the framing FSM, word assembly and write port.

Test Plan (CLKS_PER_BIT=4, AW=8):
1. Reset: hold rst low mid-idle → cpu_hold=1, imem_w_en=0, imem_w_addr=0, load_done=0, load_error=0; all remain so for 100 cycles of idle line.
2. Send 02 00 93 00 50 00 13 01 10 00 C1 → imem_w_en pulses twice (addr 0, data 0x00500093; addr 1, data 0x00100113); load_done=1; cpu_hold=0.
3. Same stream with checksum C0 → both writes still occur; load_error=1; cpu_hold=1. A subsequent correct stream → load_done=1, load_error=0.
4. Send 00 01 (N=256) → accepted. Send 01 01 (N=257) or 00 00 → ERROR immediately, no writes.
5. Send a byte with stop bit 0 during DATA → ERROR. Separately, a 1-cycle low glitch on uart_rx → no byte, state unchanged.
6. Assert rst after 5 data bytes of test 2 → outputs return to reset values. Full stream resent → writes start again at addr 0.
